// File: rtl/cache_miss_handler.sv
// Miss-service stage behind cache_system: applies L2 wait or memory
// handshake latency, stalls upstream, reports completions and stats.
module cache_miss_handler #(
  parameter int ADDR_W = 11,
  parameter int L2_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic              l1_hit,
  input  logic              l2_hit,
  input  logic              miss,
  output logic              stall,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              done,
  output logic [ADDR_W-1:0] done_addr,
  output logic [1:0]        done_src,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  l1_cnt,
  output logic [CNT_W-1:0]  l2_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    L2_WAIT,
    MEM_REQ
  } state_t;

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [7:0] WAIT_INIT = 8'(L2_LAT - 1);

  state_t            state;
  state_t            state_nx;
  logic              res_valid;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        wait_cnt;
  logic [7:0]        wait_nx;
  logic              one_hot;
  logic              accept;
  logic              done_nx;
  logic [1:0]        src_nx;
  logic [ADDR_W-1:0] daddr_nx;

  // xor of three is high for one or three set; exclude three
  assign one_hot = (l1_hit ^ l2_hit ^ miss) & ~(l1_hit & l2_hit & miss);
  assign accept  = (state == IDLE) & res_valid & one_hot;
  assign stall   = (state != IDLE) | (accept & (l2_hit | miss));
  assign mem_addr = cap_addr;

  // Result-cycle pipeline: valid and address matching this cycle's result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      addr_d    <= '0;
    end else begin
      res_valid <= in_valid;
      addr_d    <= addr;
    end
  end

  // Next-state, wait countdown and completion decode
  always_comb begin
    state_nx = state;
    wait_nx  = wait_cnt;
    done_nx  = 1'b0;
    src_nx   = 2'b00;
    daddr_nx = done_addr;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            l1_hit: begin
              done_nx  = 1'b1;
              src_nx   = 2'b01;
              daddr_nx = addr_d;
            end
            l2_hit: begin
              state_nx = L2_WAIT;
              wait_nx  = WAIT_INIT;
            end
            default: state_nx = MEM_REQ;
          endcase
        end
      end
      L2_WAIT: begin
        if (wait_cnt == 8'd0) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          src_nx   = 2'b10;
          daddr_nx = cap_addr;
        end else begin
          wait_nx = wait_cnt - 8'd1;
        end
      end
      MEM_REQ: begin
        if (mem_ack) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
          src_nx   = 2'b11;
          daddr_nx = cap_addr;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // FSM state, captured address and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      cap_addr  <= '0;
      mem_req   <= 1'b0;
      done      <= 1'b0;
      done_src  <= 2'b00;
      done_addr <= '0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_nx;
      mem_req   <= (state_nx == MEM_REQ);
      done      <= done_nx;
      done_src  <= src_nx;
      done_addr <= daddr_nx;
      if (accept && !l1_hit) cap_addr <= addr_d;
    end
  end

  // Saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l1_cnt    <= '0;
      l2_cnt    <= '0;
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else if (clr_stats) begin
      l1_cnt    <= '0;
      l2_cnt    <= '0;
      miss_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept && l1_hit && l1_cnt != CMAX)
        l1_cnt <= l1_cnt + 1'b1;
      if (accept && l2_hit && l2_cnt != CMAX)
        l2_cnt <= l2_cnt + 1'b1;
      if (accept && miss && miss_cnt != CMAX)
        miss_cnt <= miss_cnt + 1'b1;
      if (stall && stall_cnt != CMAX)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: doc/cache_miss_handler.md
# cache_miss_handler

Downstream service stage for `cache_system`. It consumes the one-cycle `l1_hit` / `l2_hit` / `miss` result and applies per-level service latency: L2 wait countdown or main-memory request/acknowledge handshake. While servicing, it stalls the upstream address source and reports each completed access with its source level. It also keeps saturating per-level hit/miss and stall-cycle statistics for the simulator.

## Interface
Parameters:
- `ADDR_W`, 11, address width; matches `cache_system` address.
- `L2_LAT`, 4, L2 service cycles after the result cycle; legal range 1..255.
- `CNT_W`, 16, width of each statistics counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream drives a valid `addr` this cycle.
- `addr`  in  ADDR_W  address presented to `cache_system` this cycle; upstream holds it while `stall`=1.
- `l1_hit`, `l2_hit`, `miss`  in  1 each  `cache_system` result for the address presented in the previous cycle; at most one is high.
- `stall`  out  1  combinational; upstream must hold `addr` and `in_valid` this cycle.
- `mem_req`  out  1  main-memory fill request, registered.
- `mem_addr`  out  ADDR_W  fill address, stable while `mem_req`=1.
- `mem_ack`  in  1  memory accepts/completes the fill; sampled only while `mem_req`=1.
- `done`  out  1  one-cycle pulse, access complete, registered.
- `done_addr`  out  ADDR_W  address of the completed access; valid when `done`=1.
- `done_src`  out  2  01 = L1, 10 = L2, 11 = memory; 00 when `done`=0.
- `clr_stats`  in  1  synchronous clear of all statistics counters.
- `l1_cnt`, `l2_cnt`, `miss_cnt`, `stall_cnt`  out  CNT_W each  saturating statistics.

## Operation
- Internal registers:
  - `res_valid` = `in_valid` delayed one cycle.
  - `addr_d` = `addr` delayed one cycle. It is the address matching the current result.
- A result is accepted in a cycle when `state`=IDLE, `res_valid`=1, and exactly one result input is high. Results in any other state are ignored. The held address is re-evaluated, and its result is accepted once the FSM returns to IDLE.
- FSM states: IDLE, L2_WAIT, MEM_REQ.
- IDLE, accepted `l1_hit`: stay IDLE. Next cycle `done`=1, `done_src`=01, `done_addr`=`addr_d`. `l1_cnt`++.
- IDLE, accepted `l2_hit`: go to L2_WAIT, load `wait_cnt` = L2_LAT-1 (8-bit), capture `addr_d`. `l2_cnt`++.
- IDLE, accepted `miss`: go to MEM_REQ, capture `addr_d` into `mem_addr`. `miss_cnt`++.
- L2_WAIT: decrement `wait_cnt`. When `wait_cnt`=0, go to IDLE; next cycle `done`=1, `done_src`=10.
- MEM_REQ: `mem_req`=1. On `mem_ack`=1, go to IDLE and drop `mem_req`; next cycle `done`=1, `done_src`=11. There is no timeout.
- `stall` = (`state`≠IDLE) | (IDLE & accepted `l2_hit` or `miss`).
- `stall_cnt`++ every cycle `stall`=1.
- All counters saturate at 2^CNT_W-1. `clr_stats` zeroes all counters and wins over a same-cycle increment.
- `mem_ack` outside MEM_REQ is ignored. Illegal result inputs (more than one high) are not accepted and change no state.

## Timing
- Reset (`rst_n`=0, async) sets:
  - `state`=IDLE
  - `stall` = `mem_req` = `done` = 0
  - `done_src` = 0, `done_addr` = 0, `mem_addr` = 0
  - `res_valid` = 0, all counters 0
- Reset during MEM_REQ drops `mem_req` immediately; the in-flight access is lost with no `done`.
- Latency from result cycle t:
  - L1: `done` at t+1, no stall.
  - L2: `stall` high t..t+L2_LAT, `done` at t+L2_LAT+1.
  - Miss: `stall` high t..k, where k is the first MEM_REQ cycle with `mem_ack`=1; `done` at k+1. `mem_req` high t+1..k.
- Minimum miss latency: `mem_ack` tied high gives k=t+1 and `done` at t+2.
- Back-to-back L1 hits give one `done` per cycle.
- A new result is accepted in the same cycle `done` pulses for the previous access.

## Test plan
- Reset mid-MEM_REQ (`mem_req`=1) -> `mem_req`, `stall`, `done` go 0 asynchronously; counters read 0; first accepted result after release is handled normally.
- Four consecutive L1 hits, addresses 0x010..0x013 -> `done` on four consecutive cycles, `done_src`=01, matching `done_addr`; `stall` never high; `l1_cnt`=4.
- L2 hit on 0x2A5 at cycle 10 (L2_LAT=4) -> `stall` high cycles 10..14; `done` at 15 with `done_src`=10 and `done_addr`=0x2A5; `stall_cnt`=5; held-address result at 15 accepted.
- Miss on 0x7FF with `mem_ack` delayed 6 cycles after `mem_req` -> `mem_req`/`mem_addr`=0x7FF stable throughout; `done_src`=11 one cycle after ack; spurious `mem_ack` pulse while IDLE ignored.
- L2_LAT=1, L2 hit at cycle t -> `stall` high t..t+1, `done` at t+2.
- CNT_W=4, 17 L1 hits -> `l1_cnt` saturates at 15; `clr_stats` pulsed in the same cycle as a hit -> `l1_cnt`=0.
